gmii_rx_framer: RTL and testbench

Receive-side framer that sits directly downstream of the GMII FCS-strip stage. It consumes the byte stream with FCS already removed and preamble still present, then locates the SFD and packs payload bytes big-endian into 32-bit words. It marks start/end of frame, valid-byte count and error status on each word, and keeps good/bad frame counters. There is no backpressure, because GMII cannot stall.

---
 rtl/gmii_rx_framer_if.sv | 29 ++
 rtl/gmii_rx_framer.sv | 134 +++++++++++++
 tb/tb_gmii_rx_framer.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gmii_rx_framer_if.sv
// Bus bundle for the GMII receive framer: byte stream in, packed words and
// frame counters out. The framer uses the slave view; the byte source and
// packet sink side uses the master view.
interface gmii_rx_framer_if;
  logic        gmii_en_i;
  logic        gmii_er_i;
  logic [7:0]  gmii_data_i;
  logic        pkt_valid_o;
  logic        pkt_sop_o;
  logic        pkt_eop_o;
  logic [31:0] pkt_data_o;
  logic [1:0]  pkt_mod_o;
  logic        pkt_err_o;
  logic [10:0] pkt_len_o;
  logic [31:0] good_cnt_o;
  logic [31:0] bad_cnt_o;

  modport master (
    output gmii_en_i, gmii_er_i, gmii_data_i,
    input  pkt_valid_o, pkt_sop_o, pkt_eop_o, pkt_data_o, pkt_mod_o,
    input  pkt_err_o, pkt_len_o, good_cnt_o, bad_cnt_o
  );

  modport slave (
    input  gmii_en_i, gmii_er_i, gmii_data_i,
    output pkt_valid_o, pkt_sop_o, pkt_eop_o, pkt_data_o, pkt_mod_o,
    output pkt_err_o, pkt_len_o, good_cnt_o, bad_cnt_o
  );
endinterface

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: finds the SFD, packs payload bytes big-endian into
// 32-bit words, tags sop/eop/mod/len/err on each word and counts good and
// bad frames. No backpressure; every output is registered.
module gmii_rx_framer #(
  parameter int unsigned MIN_LEN = 60,
  parameter int unsigned MAX_LEN = 1514
) (
  input logic            clk,
  input logic            rst_n,
  gmii_rx_framer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  localparam logic [7:0]  PRE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE = 8'hD5;
  localparam logic [10:0] LEN_SAT  = 11'd2047;
  localparam logic [10:0] MIN_L    = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L    = 11'(MAX_LEN);

  state_t      state;
  logic [31:0] asm_word;    // word under assembly; unused lanes stay zero
  logic [1:0]  lane;        // next byte lane, wraps independently of len
  logic        word_full;   // asm_word complete, waiting for next byte or end
  logic        first_word;  // next emitted word is the frame's first
  logic [10:0] len;         // payload bytes so far, saturating
  logic        er_seen;     // sticky receive error within DATA
  logic        frame_err;

  // Frame error as it would be reported if the frame ended now.
  always_comb frame_err = er_seen || (len < MIN_L) || (len > MAX_L);

  // Framer state machine with registered word and counter outputs.
  // NOTE: asynchronous active-low reset; every register including the
  // datapath is cleared so a mid-frame reset leaves no stale word behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      asm_word        <= '0;
      lane            <= '0;
      word_full       <= 1'b0;
      first_word      <= 1'b0;
      len             <= '0;
      er_seen         <= 1'b0;
      bus.pkt_valid_o <= 1'b0;
      bus.pkt_sop_o   <= 1'b0;
      bus.pkt_eop_o   <= 1'b0;
      bus.pkt_data_o  <= '0;
      bus.pkt_mod_o   <= '0;
      bus.pkt_err_o   <= 1'b0;
      bus.pkt_len_o   <= '0;
      bus.good_cnt_o  <= '0;
      bus.bad_cnt_o   <= '0;
    end else begin
      // NOTE: strobe outputs get a non-blocking default here; a later
      // assignment in the same block wins, so they pulse for one cycle only.
      bus.pkt_valid_o <= 1'b0;
      bus.pkt_sop_o   <= 1'b0;
      bus.pkt_eop_o   <= 1'b0;
      bus.pkt_data_o  <= '0;
      bus.pkt_mod_o   <= '0;
      bus.pkt_err_o   <= 1'b0;
      bus.pkt_len_o   <= '0;

      unique case (state)
        IDLE, PREAMBLE: begin
          if (bus.gmii_en_i) begin
            if (bus.gmii_data_i == SFD_BYTE) begin
              state      <= DATA;
              lane       <= '0;
              word_full  <= 1'b0;
              first_word <= 1'b1;
              len        <= '0;
              er_seen    <= 1'b0;
            end else if (bus.gmii_data_i == PRE_BYTE) begin
              state <= PREAMBLE;
            end else begin
              state <= DROP;
            end
          end else begin
            state <= IDLE;
          end
        end

        DATA: begin
          if (bus.gmii_en_i) begin
            // First byte of a new word releases the previously completed one.
            if (lane == 2'd0 && word_full) begin
              bus.pkt_valid_o <= 1'b1;
              bus.pkt_sop_o   <= first_word;
              bus.pkt_data_o  <= asm_word;
              first_word      <= 1'b0;
            end
            unique case (lane)
              2'd0: asm_word        <= {bus.gmii_data_i, 24'h0};
              2'd1: asm_word[23:16] <= bus.gmii_data_i;
              2'd2: asm_word[15:8]  <= bus.gmii_data_i;
              2'd3: asm_word[7:0]   <= bus.gmii_data_i;
            endcase
            lane      <= lane + 2'd1;
            word_full <= (lane == 2'd3);
            if (len != LEN_SAT) len <= len + 11'd1;
            er_seen   <= er_seen | bus.gmii_er_i;
          end else begin
            state <= IDLE;
            if (len == '0) begin
              bus.bad_cnt_o <= bus.bad_cnt_o + 32'd1;
            end else begin
              bus.pkt_valid_o <= 1'b1;
              bus.pkt_sop_o   <= first_word;
              bus.pkt_eop_o   <= 1'b1;
              bus.pkt_data_o  <= asm_word;
              bus.pkt_mod_o   <= len[1:0];
              bus.pkt_err_o   <= frame_err;
              bus.pkt_len_o   <= len;
              if (frame_err) bus.bad_cnt_o  <= bus.bad_cnt_o + 32'd1;
              else           bus.good_cnt_o <= bus.good_cnt_o + 32'd1;
            end
          end
        end

        DROP: begin
          if (!bus.gmii_en_i) begin
            state         <= IDLE;
            bus.bad_cnt_o <= bus.bad_cnt_o + 32'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Self-checking bench for gmii_rx_framer: table of directed frames, a
// back-to-back pair, a mid-frame reset and randomized frames, all scored
// against a frame-level reference model.
module tb_gmii_rx_framer;

  localparam int MIN_LEN = 60;
  localparam int MAX_LEN = 1514;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  gmii_rx_framer_if bus ();

  gmii_rx_framer #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #4 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  mod;
    logic        err;
    logic [10:0] len;
  } word_t;

  typedef struct packed {
    logic [7:0] d;
    logic       er;
  } gbyte_t;

  typedef gbyte_t gq_t[$];

  typedef struct {
    int          pre_n;
    logic [7:0]  lead;
    int          n;
    int          er_at;
    int          words;
    logic [31:0] last;
    logic [1:0]  mod;
    int          len;
    bit          err;
    int          good_d;
    int          bad_d;
  } vec_t;

  word_t       exp_q[$];
  word_t       got_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned exp_good = 0;
  int unsigned exp_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Word monitor: every strobe is captured and scored against the model.
  always @(negedge clk) begin : monitor
    word_t w;
    if (bus.pkt_valid_o === 1'b1) begin
      w.data = bus.pkt_data_o;
      w.sop  = bus.pkt_sop_o;
      w.eop  = bus.pkt_eop_o;
      w.mod  = bus.pkt_mod_o;
      w.err  = bus.pkt_err_o;
      w.len  = bus.pkt_len_o;
      got_q.push_back(w);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL word_unexpected: got %h, expected no word", w);
      end else begin
        check("word", w, exp_q.pop_front());
      end
    end
  end

  // Reference model: parse a byte stream by the framing rules, queue the
  // expected words and update the expected counters.
  task automatic model_stream(input gq_t s);
    int          i;
    int          n;
    int          ls;
    bit          er;
    bit          err;
    logic [7:0]  pl[$];
    word_t       w;
    i  = 0;
    er = 1'b0;
    while (i < s.size() && s[i].d == 8'h55) i++;
    if (i >= s.size()) return;
    if (s[i].d != 8'hD5) begin
      exp_bad++;
      return;
    end
    for (int k = i + 1; k < s.size(); k++) begin
      pl.push_back(s[k].d);
      er |= s[k].er;
    end
    n = pl.size();
    if (n == 0) begin
      exp_bad++;
      return;
    end
    err = er || (n < MIN_LEN) || (n > MAX_LEN);
    ls  = (n > 2047) ? 2047 : n;
    for (int b = 0; b < n; b += 4) begin
      w = '0;
      for (int j = 0; j < 4; j++)
        if (b + j < n) w.data[31 - 8*j -: 8] = pl[b + j];
      w.sop = (b == 0);
      w.eop = (b + 4 >= n);
      if (w.eop) begin
        w.mod = 2'(ls % 4);
        w.len = 11'(ls);
        w.err = err;
      end
      exp_q.push_back(w);
    end
    if (err) exp_bad++;
    else     exp_good++;
  endtask

  function automatic gq_t build(input int pre_n, input logic [7:0] lead,
                                input int n, input int er_at, input bit rnd);
    gq_t    s;
    gbyte_t g;
    for (int k = 0; k < pre_n; k++) begin
      g.d  = 8'h55;
      g.er = rnd && ($urandom_range(0, 15) == 0);
      s.push_back(g);
    end
    g.d  = lead;
    g.er = rnd && ($urandom_range(0, 15) == 0);
    s.push_back(g);
    for (int k = 0; k < n; k++) begin
      g.d  = rnd ? 8'($urandom) : 8'(k);
      g.er = (k == er_at);
      s.push_back(g);
    end
    return s;
  endfunction

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      bus.gmii_en_i   = 1'b0;
      bus.gmii_er_i   = 1'b0;
      bus.gmii_data_i = 8'h00;
    end
  endtask

  task automatic drive(input gq_t s, input int gap);
    foreach (s[k]) begin
      @(negedge clk);
      bus.gmii_en_i   = 1'b1;
      bus.gmii_data_i = s[k].d;
      bus.gmii_er_i   = s[k].er;
    end
    idle(gap);
  endtask

  task automatic settle(input string name);
    idle(3);
    #1;
    check({name, "_pending_words"}, exp_q.size(), 0);
    check({name, "_good_cnt"}, bus.good_cnt_o, exp_good);
    check({name, "_bad_cnt"}, bus.bad_cnt_o, exp_bad);
    exp_q.delete();
  endtask

  initial begin
    #(8 * 200000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[12];
    gq_t         s1;
    gq_t         s2;
    word_t       lw;
    int unsigned tbl_good;
    int unsigned tbl_bad;
    int          n;
    int          er_at;
    logic [7:0]  lead;

    bus.gmii_en_i   = 1'b0;
    bus.gmii_er_i   = 1'b0;
    bus.gmii_data_i = 8'h00;

    //          pre lead   n     er  words last          mod len   err g b
    tbl[0]  = '{7, 8'hD5, 64,   -1, 16,  32'h3C3D3E3F, 0, 64,   0, 1, 0};
    tbl[1]  = '{0, 8'hD5, 61,   -1, 16,  32'h3C000000, 1, 61,   0, 1, 0};
    tbl[2]  = '{1, 8'hD5, 10,   -1, 3,   32'h08090000, 2, 10,   1, 0, 1};
    tbl[3]  = '{7, 8'hD5, 100,  50, 25,  32'h60616263, 0, 100,  1, 0, 1};
    tbl[4]  = '{0, 8'h12, 19,   -1, 0,   32'h0,        0, 0,    0, 0, 1};
    tbl[5]  = '{7, 8'hD5, 1,    -1, 1,   32'h00000000, 1, 1,    1, 0, 1};
    tbl[6]  = '{7, 8'hD5, 0,    -1, 0,   32'h0,        0, 0,    0, 0, 1};
    tbl[7]  = '{2, 8'hD5, 60,   -1, 15,  32'h38393A3B, 0, 60,   0, 1, 0};
    tbl[8]  = '{2, 8'hD5, 59,   -1, 15,  32'h38393A00, 3, 59,   1, 0, 1};
    tbl[9]  = '{2, 8'hD5, 1514, -1, 379, 32'hE8E90000, 2, 1514, 0, 1, 0};
    tbl[10] = '{2, 8'hD5, 1515, -1, 379, 32'hE8E9EA00, 3, 1515, 1, 0, 1};
    tbl[11] = '{3, 8'h55, 0,    -1, 0,   32'h0,        0, 0,    0, 0, 0};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", bus.pkt_valid_o, 0);
    check("rst_sop_eop", {bus.pkt_sop_o, bus.pkt_eop_o, bus.pkt_err_o}, 0);
    check("rst_data", bus.pkt_data_o, 0);
    check("rst_mod_len", {bus.pkt_mod_o, bus.pkt_len_o}, 0);
    check("rst_good", bus.good_cnt_o, 0);
    check("rst_bad", bus.bad_cnt_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Directed frame table
    tbl_good = 0;
    tbl_bad  = 0;
    for (int r = 0; r < 12; r++) begin
      got_q.delete();
      s1 = build(tbl[r].pre_n, tbl[r].lead, tbl[r].n, tbl[r].er_at, 1'b0);
      model_stream(s1);
      drive(s1, 1);
      settle($sformatf("tbl%0d", r));
      tbl_good += tbl[r].good_d;
      tbl_bad  += tbl[r].bad_d;
      check($sformatf("tbl%0d_words", r), got_q.size(), tbl[r].words);
      check($sformatf("tbl%0d_good", r), bus.good_cnt_o, tbl_good);
      check($sformatf("tbl%0d_bad", r), bus.bad_cnt_o, tbl_bad);
      if (tbl[r].words > 0 && got_q.size() > 0) begin
        lw = got_q[got_q.size() - 1];
        check($sformatf("tbl%0d_last_data", r), lw.data, tbl[r].last);
        check($sformatf("tbl%0d_last_tags", r), {lw.eop, lw.mod, lw.err, lw.len},
              {1'b1, tbl[r].mod, tbl[r].err, 11'(tbl[r].len)});
        check($sformatf("tbl%0d_first_sop", r), got_q[0].sop, 1);
      end
    end

    // Two 64-byte frames separated by a single idle cycle
    got_q.delete();
    s1 = build(7, 8'hD5, 64, -1, 1'b0);
    s2 = build(7, 8'hD5, 64, -1, 1'b0);
    model_stream(s1);
    model_stream(s2);
    drive(s1, 1);
    drive(s2, 1);
    settle("b2b");
    check("b2b_words", got_q.size(), 32);
    check("b2b_good", bus.good_cnt_o, tbl_good + 2);

    // Reset asserted in the middle of the second frame, released while en=1
    s1 = build(7, 8'hD5, 64, -1, 1'b0);
    s2 = build(7, 8'hD5, 64, -1, 1'b0);
    model_stream(s1);
    model_stream(s2);
    drive(s1, 1);
    for (int k = 0; k < s2.size(); k++) begin
      @(negedge clk);
      if (k == 38) rst_n = 1'b0;
      if (k == 41) rst_n = 1'b1;
      bus.gmii_en_i   = 1'b1;
      bus.gmii_data_i = s2[k].d;
      bus.gmii_er_i   = s2[k].er;
      if (k == 38) begin
        #1;
        exp_q.delete();
        exp_good = 0;
        exp_bad  = 0;
        check("mid_rst_valid", bus.pkt_valid_o, 0);
        check("mid_rst_data", bus.pkt_data_o, 0);
        check("mid_rst_good", bus.good_cnt_o, 0);
        check("mid_rst_bad", bus.bad_cnt_o, 0);
      end
    end
    model_stream(s2[41:$]);
    idle(1);
    settle("post_rst");

    // Randomized frames
    for (int f = 0; f < 60; f++) begin
      n     = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1500, 1520))
                                           : int'($urandom_range(0, 80));
      er_at = (n > 0 && $urandom_range(0, 7) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      lead  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'hD5;
      s1    = build(int'($urandom_range(0, 8)), lead, n, er_at, 1'b1);
      model_stream(s1);
      drive(s1, int'($urandom_range(1, 3)));
      if (f % 10 == 9) settle($sformatf("rand%0d", f));
    end
    settle("rand_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
